memcpy_dma: RTL and testbench
=============================

MEMCPY_DMA -- requirements
Module: memcpy_dma

Interface
REQ-001 Parameter ADDR_BITS, default 16, width of memory addresses and SRC/DST registers.
REQ-002 Parameter DATA_BITS, default 16, width of memory data, FILL register and register port data.
REQ-003 Parameter LEN_BITS, default 16, width of the LEN word counter.
REQ-004 CLK  input  1  system clock; all state updates on rising edge.
REQ-005 RSTb  input  1  reset, asynchronous, active-low.
REQ-006 port_addr  input  3  register select (0 SRC, 1 DST, 2 LEN, 3 CTRL, 4 STATUS, 5 FILL).
REQ-007 port_in  input  DATA_BITS  register write data.
REQ-008 port_wr  input  1  register write strobe, one cycle per write.
REQ-009 port_out  output  DATA_BITS  combinational read of the register selected by port_addr; unused bits zero.
REQ-010 mem_addr  output  ADDR_BITS  master address.
REQ-011 mem_rd  output  1  read request.
REQ-012 mem_wr  output  1  write request.
REQ-013 mem_wdata  output  DATA_BITS  write data.
REQ-014 mem_rdata  input  DATA_BITS  read data, valid in the cycle mem_ack is high for a read.
REQ-015 mem_ack  input  1  transaction complete; accepted in the same cycle as the request (zero-wait allowed).
REQ-016 irq  output  1  level interrupt = STATUS.done AND CTRL.irq_en.

Function
REQ-017 CTRL bits: 0 start (self-clearing, always reads 0), 1 fill mode, 2 irq_en, 3 abort (self-clearing, always reads 0); STATUS bits: 0 busy, 1 done, 2 aborted (read-only in STATUS, cleared by writing 1 to the matching bit).
REQ-018 States: IDLE, READ, WRITE.
REQ-019 Write to CTRL with start=1 in IDLE, LEN≠0: busy=1, done=0, aborted=0; next cycle enter READ (copy) or WRITE (fill).
REQ-020 Start with LEN=0: no memory access, done=1 on the next cycle, busy stays 0.
REQ-021 Start while busy is ignored; writes to SRC, DST, LEN, FILL while busy are ignored; CTRL irq_en writable at any time.
REQ-022 READ: mem_rd=1, mem_addr=SRC, held until mem_ack; on mem_ack latch mem_rdata, go to WRITE.
REQ-023 WRITE: mem_wr=1, mem_addr=DST, mem_wdata=latched data (copy) or FILL (fill), held until mem_ack.
REQ-024 On WRITE mem_ack: SRC+=1 (copy mode only), DST+=1, LEN-=1; if LEN was 1 go IDLE, busy=0, done=1; else go READ (copy) or stay WRITE (fill).
REQ-025 Address increments wrap modulo 2^ADDR_BITS; no fault.
REQ-026 mem_rd and mem_wr never both high; both low in IDLE; mem_addr/mem_wdata stable while a request is pending.
REQ-027 Abort while busy: current pending request stays asserted until mem_ack, then IDLE, busy=0, aborted=1, done=0; SRC/DST/LEN reflect completed words only; abort in IDLE has no effect.
REQ-028 Start and abort in the same CTRL write: abort wins, no transfer starts.
REQ-029 Throughput with mem_ack tied high: copy 2 cycles/word, fill 1 cycle/word.
REQ-030 SRC/DST/LEN read back live values during a transfer.

Reset
REQ-031 RSTb low asynchronously forces IDLE; SRC, DST, LEN, FILL, CTRL, STATUS, latched data = 0; mem_rd, mem_wr, irq = 0; mem_addr, mem_wdata = 0.
REQ-032 Reset mid-transfer abandons the pending request immediately; no further memory access after RSTb rises until a new start.

Verification
REQ-033 mem_ack=1, SRC=0x0100, DST=0x0200, LEN=4, copy start -> reads 0x0100..0x0103 each followed by write to 0x0200..0x0203 with same data, done=1 after 8 busy cycles, SRC=0x0104, DST=0x0204, LEN=0.
REQ-034 Fill, FILL=0xA5A5, DST=0x0010, LEN=3, irq_en=1 -> writes 0xA5A5 to 0x0010..0x0012 on consecutive cycles, no reads, irq=1; write STATUS=0x0002 -> irq=0.
REQ-035 LEN=0 start -> no mem_rd/mem_wr, done=1 one cycle later; DST=0xFFFF, LEN=2 fill -> writes 0xFFFF then 0x0000.
REQ-036 mem_ack delayed 3 cycles per transaction, copy LEN=2 -> mem_addr/mem_rd/mem_wr stable during waits, correct data, 16 busy cycles.
REQ-037 Abort during READ of word 2 of LEN=5 copy -> read completes, no write of word 2, aborted=1, LEN=4; second start during busy ignored.
REQ-038 RSTb pulsed low mid-WRITE -> mem_wr drops asynchronously, all registers 0, no access after release.

Source files
------------

// File: rtl/memcpy_dma.sv
// Register-programmed DMA engine: copies a block of words from SRC to DST, or fills DST with a constant,
// through a single request/acknowledge memory master port.
module memcpy_dma #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 16,
    parameter int LEN_BITS  = 16
) (
    input  logic                 CLK,
    input  logic                 RSTb,
    input  logic [2:0]           port_addr,
    input  logic [DATA_BITS-1:0] port_in,
    input  logic                 port_wr,
    output logic [DATA_BITS-1:0] port_out,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic [DATA_BITS-1:0] mem_wdata,
    input  logic [DATA_BITS-1:0] mem_rdata,
    input  logic                 mem_ack,
    output logic                 irq
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    localparam logic [2:0] A_SRC    = 3'd0;
    localparam logic [2:0] A_DST    = 3'd1;
    localparam logic [2:0] A_LEN    = 3'd2;
    localparam logic [2:0] A_CTRL   = 3'd3;
    localparam logic [2:0] A_STATUS = 3'd4;
    localparam logic [2:0] A_FILL   = 3'd5;

    state_t                 state_reg, state_next;
    logic [ADDR_BITS-1:0]   src_reg, src_next;
    logic [ADDR_BITS-1:0]   dst_reg, dst_next;
    logic [LEN_BITS-1:0]    len_reg, len_next;
    logic [DATA_BITS-1:0]   fill_reg, fill_next;
    logic [DATA_BITS-1:0]   data_reg, data_next;
    logic                   fill_mode_reg, fill_mode_next;
    logic                   irq_en_reg, irq_en_next;
    logic                   busy_reg, busy_next;
    logic                   done_reg, done_next;
    logic                   aborted_reg, aborted_next;
    logic                   abort_reg, abort_next;

    logic ctrl_wr;
    logic start_req;
    logic abort_req;
    logic abort_now;

    assign ctrl_wr   = port_wr && (port_addr == A_CTRL);
    // Abort beats start when both arrive in the same CTRL write.
    assign start_req = ctrl_wr && port_in[0] && !port_in[3];
    assign abort_req = ctrl_wr && port_in[3];
    // An abort written in the very cycle the pending request is acknowledged still takes effect.
    assign abort_now = abort_reg || (abort_req && busy_reg);

    always_comb begin
        state_next     = state_reg;
        src_next       = src_reg;
        dst_next       = dst_reg;
        len_next       = len_reg;
        fill_next      = fill_reg;
        data_next      = data_reg;
        fill_mode_next = fill_mode_reg;
        irq_en_next    = irq_en_reg;
        busy_next      = busy_reg;
        done_next      = done_reg;
        aborted_next   = aborted_reg;
        abort_next     = abort_reg;

        if (port_wr) begin
            case (port_addr)
                A_SRC:    if (!busy_reg) src_next  = ADDR_BITS'(port_in);
                A_DST:    if (!busy_reg) dst_next  = ADDR_BITS'(port_in);
                A_LEN:    if (!busy_reg) len_next  = LEN_BITS'(port_in);
                A_FILL:   if (!busy_reg) fill_next = port_in;
                A_CTRL: begin
                    irq_en_next = port_in[2];
                    if (!busy_reg) fill_mode_next = port_in[1];
                end
                A_STATUS: begin
                    if (port_in[1]) done_next    = 1'b0;
                    if (port_in[2]) aborted_next = 1'b0;
                end
                default: ;
            endcase
        end

        if (abort_req && busy_reg) abort_next = 1'b1;

        case (state_reg)
            IDLE: begin
                if (start_req) begin
                    aborted_next = 1'b0;
                    if (len_reg == '0) begin
                        done_next = 1'b1;
                    end else begin
                        done_next  = 1'b0;
                        busy_next  = 1'b1;
                        state_next = port_in[1] ? WRITE : READ;
                    end
                end
            end
            READ: begin
                if (mem_ack) begin
                    data_next = mem_rdata;
                    if (abort_now) begin
                        state_next   = IDLE;
                        busy_next    = 1'b0;
                        aborted_next = 1'b1;
                        done_next    = 1'b0;
                        abort_next   = 1'b0;
                    end else begin
                        state_next = WRITE;
                    end
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    if (!fill_mode_reg) src_next = src_reg + ADDR_BITS'(1);
                    dst_next = dst_reg + ADDR_BITS'(1);
                    len_next = len_reg - LEN_BITS'(1);
                    if (abort_now) begin
                        state_next   = IDLE;
                        busy_next    = 1'b0;
                        aborted_next = 1'b1;
                        done_next    = 1'b0;
                        abort_next   = 1'b0;
                    end else if (len_reg == LEN_BITS'(1)) begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        state_next = fill_mode_reg ? WRITE : READ;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state_reg     <= IDLE;
            src_reg       <= '0;
            dst_reg       <= '0;
            len_reg       <= '0;
            fill_reg      <= '0;
            data_reg      <= '0;
            fill_mode_reg <= 1'b0;
            irq_en_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            aborted_reg   <= 1'b0;
            abort_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            src_reg       <= src_next;
            dst_reg       <= dst_next;
            len_reg       <= len_next;
            fill_reg      <= fill_next;
            data_reg      <= data_next;
            fill_mode_reg <= fill_mode_next;
            irq_en_reg    <= irq_en_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            aborted_reg   <= aborted_next;
            abort_reg     <= abort_next;
        end
    end

    // Master outputs decode straight from the state register so reset drops them asynchronously.
    always_comb begin
        mem_rd    = (state_reg == READ);
        mem_wr    = (state_reg == WRITE);
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_reg == READ) begin
            mem_addr = src_reg;
        end else if (state_reg == WRITE) begin
            mem_addr  = dst_reg;
            mem_wdata = fill_mode_reg ? fill_reg : data_reg;
        end
    end

    always_comb begin
        port_out = '0;
        case (port_addr)
            A_SRC:    port_out = DATA_BITS'(src_reg);
            A_DST:    port_out = DATA_BITS'(dst_reg);
            A_LEN:    port_out = DATA_BITS'(len_reg);
            A_CTRL: begin
                port_out[1] = fill_mode_reg;
                port_out[2] = irq_en_reg;
            end
            A_STATUS: begin
                port_out[0] = busy_reg;
                port_out[1] = done_reg;
                port_out[2] = aborted_reg;
            end
            A_FILL:   port_out = fill_reg;
            default:  port_out = '0;
        endcase
    end

    assign irq = done_reg && irq_en_reg;

endmodule

// File: tb/tb_memcpy_dma.sv
// Directed bench for memcpy_dma: a memory responder with programmable acknowledge delay
// logs every completed transaction, and each step compares against hand-computed values.
module tb_memcpy_dma;

    logic        CLK;
    logic        RSTb;
    logic [2:0]  port_addr;
    logic [15:0] port_in;
    logic        port_wr;
    logic [15:0] port_out;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        irq;

    memcpy_dma dut (
        .CLK       (CLK),
        .RSTb      (RSTb),
        .port_addr (port_addr),
        .port_in   (port_in),
        .port_wr   (port_wr),
        .port_out  (port_out),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .irq       (irq)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Memory responder: read data is a fixed function of address (addr ^ 0x5A00).
    int ack_delay = 0;
    int cnt = 0;
    int both_err = 0;
    int stab_err = 0;
    logic        pend = 1'b0;
    logic [15:0] p_addr = '0;
    logic [15:0] p_wdata = '0;
    logic        p_rd = 1'b0;
    logic        p_wr = 1'b0;
    logic        log_wr_q[$];
    logic [15:0] log_addr_q[$];
    logic [15:0] log_data_q[$];

    assign mem_rdata = mem_rd ? (mem_addr ^ 16'h5A00) : 16'h0000;
    assign mem_ack   = (mem_rd || mem_wr) && (cnt == ack_delay);

    always @(posedge CLK) begin
        if (!RSTb) begin
            pend <= 1'b0;
            cnt  <= 0;
        end else begin
            if (mem_rd && mem_wr) both_err <= both_err + 1;
            if (pend && (mem_addr !== p_addr || mem_rd !== p_rd || mem_wr !== p_wr || mem_wdata !== p_wdata))
                stab_err <= stab_err + 1;
            if ((mem_rd || mem_wr) && mem_ack) begin
                log_wr_q.push_back(mem_wr);
                log_addr_q.push_back(mem_addr);
                log_data_q.push_back(mem_wr ? mem_wdata : mem_rdata);
                $display("txn %s addr=0x%04h data=0x%04h", mem_wr ? "WR" : "RD", mem_addr,
                         mem_wr ? mem_wdata : mem_rdata);
            end
            pend    <= (mem_rd || mem_wr) && !mem_ack;
            p_addr  <= mem_addr;
            p_wdata <= mem_wdata;
            p_rd    <= mem_rd;
            p_wr    <= mem_wr;
            cnt     <= ((mem_rd || mem_wr) && !mem_ack) ? cnt + 1 : 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called between a falling and the next rising edge; returns on the following falling edge.
    task automatic reg_write(input logic [2:0] a, input logic [15:0] d);
        port_addr = a;
        port_in   = d;
        port_wr   = 1'b1;
        @(negedge CLK);
        port_wr   = 1'b0;
        port_addr = 3'd4;
    endtask

    task automatic check_reg(input string tag, input logic [2:0] a, input logic [15:0] exp);
        @(negedge CLK);
        port_addr = a;
        #1;
        check(tag, {16'h0, port_out}, {16'h0, exp});
    endtask

    task automatic wait_idle(input int max_cycles, output int cycles);
        cycles = 0;
        port_addr = 3'd4;
        #1;
        while (port_out[0] && cycles < max_cycles) begin
            cycles++;
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic exp_log(input int i, input logic w, input logic [15:0] a, input logic [15:0] d);
        if (i >= log_addr_q.size()) begin
            check("log_present", 32'(log_addr_q.size()), 32'(i + 1));
        end else begin
            check("log_kind", {31'h0, log_wr_q[i]}, {31'h0, w});
            check("log_addr", {16'h0, log_addr_q[i]}, {16'h0, a});
            check("log_data", {16'h0, log_data_q[i]}, {16'h0, d});
        end
    endtask

    task automatic clear_log();
        log_wr_q.delete();
        log_addr_q.delete();
        log_data_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int n;
        RSTb      = 1'b0;
        port_addr = 3'd0;
        port_in   = 16'h0000;
        port_wr   = 1'b0;

        // Reset state
        #2;
        check("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
        check("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
        check_reg("rst_src", 3'd0, 16'h0000);
        check_reg("rst_status", 3'd4, 16'h0000);
        @(negedge CLK);
        RSTb = 1'b1;

        // Copy 4 words, ack tied high
        reg_write(3'd0, 16'h0100);
        reg_write(3'd1, 16'h0200);
        reg_write(3'd2, 16'h0004);
        clear_log();
        reg_write(3'd3, 16'h0001);
        wait_idle(100, cyc);
        check("copy_busy_cycles", 32'(cyc), 32'd8);
        check("copy_log_size", 32'(log_addr_q.size()), 32'd8);
        exp_log(0, 1'b0, 16'h0100, 16'h5B00);
        exp_log(1, 1'b1, 16'h0200, 16'h5B00);
        exp_log(2, 1'b0, 16'h0101, 16'h5B01);
        exp_log(3, 1'b1, 16'h0201, 16'h5B01);
        exp_log(6, 1'b0, 16'h0103, 16'h5B03);
        exp_log(7, 1'b1, 16'h0203, 16'h5B03);
        check_reg("copy_status", 3'd4, 16'h0002);
        check_reg("copy_src", 3'd0, 16'h0104);
        check_reg("copy_dst", 3'd1, 16'h0204);
        check_reg("copy_len", 3'd2, 16'h0000);
        check("copy_irq", {31'h0, irq}, 32'h0);

        // Fill 3 words with interrupt
        reg_write(3'd4, 16'h0006);
        reg_write(3'd5, 16'hA5A5);
        reg_write(3'd1, 16'h0010);
        reg_write(3'd2, 16'h0003);
        clear_log();
        reg_write(3'd3, 16'h0007);
        wait_idle(100, cyc);
        check("fill_busy_cycles", 32'(cyc), 32'd3);
        check("fill_log_size", 32'(log_addr_q.size()), 32'd3);
        exp_log(0, 1'b1, 16'h0010, 16'hA5A5);
        exp_log(1, 1'b1, 16'h0011, 16'hA5A5);
        exp_log(2, 1'b1, 16'h0012, 16'hA5A5);
        check("fill_irq", {31'h0, irq}, 32'h1);
        check_reg("fill_ctrl", 3'd3, 16'h0006);
        reg_write(3'd4, 16'h0002);
        #1;
        check("fill_irq_cleared", {31'h0, irq}, 32'h0);

        // Zero-length start
        reg_write(3'd2, 16'h0000);
        clear_log();
        reg_write(3'd3, 16'h0005);
        port_addr = 3'd4;
        #1;
        check("len0_status", {16'h0, port_out}, 32'h0002);
        check("len0_irq", {31'h0, irq}, 32'h1);
        check_reg("len0_status_later", 3'd4, 16'h0002);
        check("len0_no_access", 32'(log_addr_q.size()), 32'd0);

        // Fill across the address wrap
        reg_write(3'd4, 16'h0006);
        reg_write(3'd5, 16'h5A5A);
        reg_write(3'd1, 16'hFFFF);
        reg_write(3'd2, 16'h0002);
        clear_log();
        reg_write(3'd3, 16'h0003);
        wait_idle(100, cyc);
        check("wrap_busy_cycles", 32'(cyc), 32'd2);
        exp_log(0, 1'b1, 16'hFFFF, 16'h5A5A);
        exp_log(1, 1'b1, 16'h0000, 16'h5A5A);
        check_reg("wrap_dst", 3'd1, 16'h0001);

        // Copy 2 words with 3 wait cycles per transaction
        ack_delay = 3;
        reg_write(3'd4, 16'h0006);
        reg_write(3'd0, 16'h0300);
        reg_write(3'd1, 16'h0400);
        reg_write(3'd2, 16'h0002);
        clear_log();
        reg_write(3'd3, 16'h0001);
        wait_idle(100, cyc);
        check("slow_busy_cycles", 32'(cyc), 32'd16);
        check("slow_log_size", 32'(log_addr_q.size()), 32'd4);
        exp_log(0, 1'b0, 16'h0300, 16'h5900);
        exp_log(1, 1'b1, 16'h0400, 16'h5900);
        exp_log(2, 1'b0, 16'h0301, 16'h5901);
        exp_log(3, 1'b1, 16'h0401, 16'h5901);
        check("slow_stable", 32'(stab_err), 32'd0);
        check("slow_no_rd_wr_overlap", 32'(both_err), 32'd0);

        // Abort during the read of word 2 of a 5-word copy
        reg_write(3'd4, 16'h0006);
        reg_write(3'd0, 16'h0500);
        reg_write(3'd1, 16'h0600);
        reg_write(3'd2, 16'h0005);
        clear_log();
        reg_write(3'd3, 16'h0001);
        reg_write(3'd0, 16'h0AAA);
        n = 0;
        while (log_addr_q.size() < 2 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("abort_reached_word2", 32'(log_addr_q.size()), 32'd2);
        check("abort_in_read", {31'h0, mem_rd}, 32'h1);
        reg_write(3'd3, 16'h0001);
        reg_write(3'd3, 16'h0008);
        wait_idle(100, cyc);
        check_reg("abort_status", 3'd4, 16'h0004);
        check_reg("abort_len", 3'd2, 16'h0004);
        check_reg("abort_src", 3'd0, 16'h0501);
        check_reg("abort_dst", 3'd1, 16'h0601);
        check("abort_log_size", 32'(log_addr_q.size()), 32'd3);
        exp_log(1, 1'b1, 16'h0600, 16'h5F00);
        exp_log(2, 1'b0, 16'h0501, 16'h5F01);

        // Reset pulsed during a pending write
        reg_write(3'd4, 16'h0006);
        reg_write(3'd0, 16'h0700);
        reg_write(3'd1, 16'h0800);
        reg_write(3'd2, 16'h0003);
        reg_write(3'd3, 16'h0005);
        n = 0;
        while (!mem_wr && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("rstmid_in_write", {31'h0, mem_wr}, 32'h1);
        #2;
        RSTb = 1'b0;
        #1;
        check("rstmid_wr_async", {31'h0, mem_wr}, 32'h0);
        check("rstmid_addr", {16'h0, mem_addr}, 32'h0);
        check_reg("rstmid_src", 3'd0, 16'h0000);
        check_reg("rstmid_dst", 3'd1, 16'h0000);
        check_reg("rstmid_len", 3'd2, 16'h0000);
        check_reg("rstmid_ctrl", 3'd3, 16'h0000);
        check_reg("rstmid_status", 3'd4, 16'h0000);
        check_reg("rstmid_fill", 3'd5, 16'h0000);
        @(negedge CLK);
        RSTb = 1'b1;
        clear_log();
        repeat (10) @(negedge CLK);
        check("rstmid_no_access", 32'(log_addr_q.size()), 32'd0);
        check("rstmid_irq", {31'h0, irq}, 32'h0);
        check("final_no_rd_wr_overlap", 32'(both_err), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
